// File: rtl/div32s_pkg.sv
// Shared constants, FSM state type and magnitude helper for the sequential signed divider.
package div32s_pkg;

  localparam int unsigned DivWidth = 32;
  localparam int unsigned NumIter  = 32;
  localparam int unsigned CntWidth = 6;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  // The most negative value maps to 2^31, which still fits the unsigned 32-bit field.
  function automatic logic [DivWidth-1:0] magnitude(input logic [DivWidth-1:0] v);
    return v[DivWidth-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div32s_seq_step.sv
// One combinational restoring shift-subtract iteration on unsigned magnitudes.
module div32s_seq_step
  import div32s_pkg::*;
(
  input  logic [DivWidth:0]   rem,
  input  logic [DivWidth-1:0] quo,
  input  logic [DivWidth-1:0] dvsr,
  output logic [DivWidth:0]   rem_next,
  output logic [DivWidth-1:0] quo_next
);

  logic [DivWidth:0] shifted;
  logic [DivWidth:0] dvsr_ext;
  logic              fits;

  // Partial remainder stays below the divisor magnitude, so its top bit never feeds the shift.
  logic unused_rem_msb;
  assign unused_rem_msb = rem[DivWidth];

  assign shifted  = {rem[DivWidth-1:0], quo[DivWidth-1]};
  assign dvsr_ext = {1'b0, dvsr};
  assign fits     = (shifted >= dvsr_ext);
  assign rem_next = fits ? (shifted - dvsr_ext) : shifted;
  assign quo_next = {quo[DivWidth-2:0], fits};

endmodule

// File: rtl/div32s_seq_wrapper.sv
// Fixed-latency sequential signed divider with valid/ready handshakes on both sides.
// Optional div_by_zero output is enabled by defining DIV32S_SEQ_DBZ_FLAG_EN.
module div32s_seq_wrapper
  import div32s_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV32S_SEQ_DBZ_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam logic [CntWidth-1:0] LastIter = CntWidth'(NumIter - 1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [DivWidth:0]   rem_q, rem_d;
  logic [DivWidth-1:0] quo_q, quo_d;
  logic [DivWidth-1:0] dvsr_q, dvsr_d;
  logic [DivWidth-1:0] dvd_q, dvd_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dbz_q, dbz_d;
  logic [DivWidth-1:0] quotient_q, quotient_d;
  logic [DivWidth-1:0] remainder_q, remainder_d;

  logic [DivWidth:0]   step_rem;
  logic [DivWidth-1:0] step_quo;

  div32s_seq_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvsr     (dvsr_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    dvd_d       = dvd_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d   = StCalc;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = magnitude(dividend);
          dvsr_d    = magnitude(divisor);
          dvd_d     = dividend;
          neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d = dividend[WIDTH-1];
          dbz_d     = (divisor == '0);
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == LastIter) begin
          cnt_d   = '0;
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StFix: begin
        state_d = StDone;
        // Divide-by-zero bypasses the iteration result but keeps the same latency.
        if (dbz_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else begin
          quotient_d  = neg_quo_q ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -rem_q[DivWidth-1:0] : rem_q[DivWidth-1:0];
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      dvd_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      dvd_q       <= dvd_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

`ifdef DIV32S_SEQ_DBZ_FLAG_EN
  logic dbz_flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_flag_q <= 1'b0;
    end else if (state_q == StFix) begin
      dbz_flag_q <= dbz_q;
    end
  end

  assign div_by_zero = dbz_flag_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div32s_seq_wrapper.sv
// Scoreboard bench for div32s_seq_wrapper: directed corner cases, random operands, back-pressure
// and mid-division reset, checked against plain integer arithmetic.
module tb_div32s_seq_wrapper;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          acc;
  } exp_t;

  localparam logic [31:0] Min = 32'h8000_0000;
  localparam logic [31:0] Max = 32'h7FFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
`ifdef DIV32S_SEQ_DBZ_FLAG_EN
  logic        div_by_zero;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  exp_t sb[$];

  div32s_seq_wrapper #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV32S_SEQ_DBZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer back-pressure: 0 always ready, 1 random, 2 held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dbz);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.acc = 0;
    return e;
  endfunction

  // Truncating signed division; 64-bit arithmetic makes MIN / -1 wrap back to MIN naturally.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    longint la = longint'($signed(a));
    longint lb = longint'($signed(b));
    if (b == 32'd0) return mk(32'hFFFF_FFFF, a, 1'b1);
    return mk(32'(la / lb), 32'(la % lb), 1'b0);
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e,
                       input bit track);
    int guard = 0;
    while (!in_ready && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 required 1");
      return;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.acc = cyc;
    if (track) sb.push_back(e);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sb.size() != 0 || !in_ready) && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (guard >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
    end
  endtask

  // Monitor: latency, hold-while-stalled, post-handshake behaviour and result values.
  initial begin
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    bit          prev_hs = 1'b0;
    logic [31:0] held_q = '0;
    logic [31:0] held_r = '0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (prev_hs) begin
          chk("in_ready_after_hs", 32'(in_ready), 32'd1);
          chk("out_valid_after_hs", 32'(out_valid), 32'd0);
          chk("quotient_kept", quotient, last_q);
          chk("remainder_kept", remainder, last_r);
        end
        if (out_valid && !prev_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got out_valid 1 required 0 (cycle %0d)", cyc);
          end else begin
            chk("latency", 32'(cyc - sb[0].acc), 32'd33);
          end
        end
        if (out_valid && prev_valid && !prev_ready) begin
          chk("stall_quotient", quotient, held_q);
          chk("stall_remainder", remainder, held_r);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        prev_hs = out_valid && out_ready;
        if (prev_hs && sb.size() > 0) begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
`ifdef DIV32S_SEQ_DBZ_FLAG_EN
          chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
`endif
          last_q = quotient;
          last_r = remainder;
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        held_q     = quotient;
        held_r     = remainder;
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    bit          saw_valid;
    int          guard;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), 1'b1);
    issue(-32'sd100, 32'd7, mk(-32'sd14, -32'sd2, 1'b0), 1'b1);
    issue(32'd100, -32'sd7, mk(-32'sd14, 32'd2, 1'b0), 1'b1);
    issue(32'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1), 1'b1);
    issue(Min, 32'hFFFF_FFFF, mk(Min, 32'd0, 1'b0), 1'b1);
    issue(Min, 32'd1, mk(Min, 32'd0, 1'b0), 1'b1);
    issue(-32'sd7, 32'd0, mk(32'hFFFF_FFFF, -32'sd7, 1'b1), 1'b1);
    issue(Min, Min, mk(32'd1, 32'd0, 1'b0), 1'b1);
    issue(32'd7, Min, mk(32'd0, 32'd7, 1'b0), 1'b1);
    issue(Max, 32'hFFFF_FFFF, mk(32'h8000_0001, 32'd0, 1'b0), 1'b1);
    issue(32'hFFFF_FFFF, 32'd2, mk(32'd0, 32'hFFFF_FFFF, 1'b0), 1'b1);
    wait_idle();

    // Back-pressure: result held for ten cycles while junk operands are offered.
    rdy_mode = 2;
    issue(32'd1234, -32'sd17, model(32'd1234, -32'sd17), 1'b1);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("stall_result_seen", 32'(out_valid), 32'd1);
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'd3;
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_still_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    rdy_mode = 0;
    wait_idle();

    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 4))
        1: b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 20)) :
                                             -32'($urandom_range(1, 20));
        2: b = 32'd0;
        3: a = Min;
        4: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      issue(a, b, model(a, b), 1'b1);
    end
    rdy_mode = 0;
    wait_idle();

    // Reset after ten CALC iterations must abort silently.
    issue(32'd999, 32'd4, model(32'd999, 32'd4), 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abort_no_result", 32'(saw_valid), 32'd0);

    issue(-32'sd50, 32'd6, mk(-32'sd8, -32'sd2, 1'b0), 1'b1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
